// File: rtl/antares_div_seq.sv
// antares_div_seq: multi-cycle restoring divider for MIPS DIV/DIVU.
// Quotient goes to LO and remainder to HI. Signed operands are divided as
// magnitudes, and the signs are fixed up in a final cycle.
module antares_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_s,
  input  logic             start_u,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] count;
  logic accept;

  // Working datapath. It is loaded on accept and is never reset.
  logic [WIDTH-1:0] rem_w, quo_w, div_mag;
  logic             signed_op, sign_q, sign_r;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  // The magnitude of a two's-complement value. The most negative value maps
  // to itself, and read as unsigned that is already the correct magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    abs_mag = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Negate the value only when asked to. The arithmetic wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    neg_if = en ? WIDTH'(-v) : v;
  endfunction

  // A start is taken only in IDLE. A flush in the same cycle suppresses it.
  assign accept = (state == IDLE) && (start_s || start_u) && !flush;
  assign busy   = (state != IDLE);

  // One restoring step. The partial remainder is always below the divisor,
  // so the WIDTH+1-bit difference carries a valid sign bit.
  assign shifted = {rem_w, quo_w[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_mag};

  assign q_fix = neg_if(signed_op && sign_q, quo_w);
  assign r_fix = neg_if(signed_op && sign_r, rem_w);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A flush aborts any operation in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = DIV;
      DIV:  if (flush) state_nxt = IDLE;
            else if (count == LAST_STEP) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step counter. It is cleared on accept and advances once per DIV cycle.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (accept)        count <= '0;
    else if (state == DIV)  count <= count + 1'b1;
  end

  // Operand capture and the iterative subtract-and-shift.
  always_ff @(posedge clk) begin
    if (accept) begin
      signed_op <= start_s;
      rem_w     <= '0;
      if (start_s) begin
        quo_w   <= abs_mag(dividend);
        div_mag <= abs_mag(divisor);
        sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        sign_r  <= dividend[WIDTH-1];
      end else begin
        quo_w   <= dividend;
        div_mag <= divisor;
        sign_q  <= 1'b0;
        sign_r  <= 1'b0;
      end
    end else if (state == DIV) begin
      rem_w <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_w <= {quo_w[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  // Result registers and the done pulse. Results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (state == FIX && !flush) begin
        done      <= 1'b1;
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_antares_div_seq.sv
// Directed testbench for antares_div_seq. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_antares_div_seq;

  logic        clk = 1'b0;
  logic        rst, flush, start_s, start_u;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;

  antares_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start_s(start_s), .start_u(start_u),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // The caller is at a falling edge. The start is held for one rising edge.
  // On return the bench is in the first busy cycle.
  task automatic do_start(input logic s, input logic u, input logic [31:0] a, input logic [31:0] b);
    start_s = s; start_u = u; dividend = a; divisor = b;
    @(negedge clk);
    start_s = 1'b0; start_u = 1'b0;
  endtask

  // Counts cycles from the start edge until done is seen, with a time limit.
  // lat stays -1 if done never appears.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1; busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin lat = i; break; end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start_s = 1'b0; start_u = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 32'h0) $display("FAIL reset_q got %h want 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h0) $display("FAIL reset_r got %h want 0", remainder); else n_pass++;
  endtask

  task automatic test_divu();
    int lat; bit bok;
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    n_checks++; if (busy !== 1'b1) $display("FAIL divu_busy_first got %0b want 1", busy); else n_pass++;
    wait_done(lat, bok);
    n_checks++; if (lat !== 34) $display("FAIL divu_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL divu_busy_held got %0b want 1", bok); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL divu_busy_at_done got %0b want 0", busy); else n_pass++;
    n_checks++; if (quotient !== 32'd14) $display("FAIL divu_q got %0d want 14", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'd2) $display("FAIL divu_r got %0d want 2", remainder); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL divu_done_pulse got %0b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 32'd14) $display("FAIL divu_q_hold got %0d want 14", quotient); else n_pass++;
  endtask

  task automatic test_div_signed();
    int lat; bit bok;
    do_start(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bok);
    n_checks++; if (lat !== 34) $display("FAIL sdiv_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (quotient !== 32'hFFFFFFFD) $display("FAIL sdiv_q got %h want fffffffd", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'hFFFFFFFF) $display("FAIL sdiv_r got %h want ffffffff", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat; bit bok;
    do_start(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bok);
    n_checks++; if (quotient !== 32'h80000000) $display("FAIL ovf_q got %h want 80000000", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h0) $display("FAIL ovf_r got %h want 0", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    do_start(1'b0, 1'b1, 32'h12345678, 32'h0);
    wait_done(lat, bok);
    n_checks++; if (lat !== 34) $display("FAIL dz_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (quotient !== 32'hFFFFFFFF) $display("FAIL dz_q got %h want ffffffff", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h12345678) $display("FAIL dz_r got %h want 12345678", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; bit bok; bit seen;
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_done got %0b want 0", seen); else n_pass++;
    n_checks++; if (quotient !== 32'hFFFFFFFF) $display("FAIL abort_q_hold got %h want ffffffff", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h12345678) $display("FAIL abort_r_hold got %h want 12345678", remainder); else n_pass++;
    // A flush in the same cycle as a start blocks the start.
    flush = 1'b1;
    do_start(1'b0, 1'b1, 32'd5, 32'd1);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_beats_start got %0b want 0", busy); else n_pass++;
    do_start(1'b1, 1'b0, 32'd9, 32'hFFFFFFFD);
    wait_done(lat, bok);
    n_checks++; if (quotient !== 32'hFFFFFFFD) $display("FAIL restart_q got %h want fffffffd", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h0) $display("FAIL restart_r got %h want 0", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int lat; bit bok;
    do_start(1'b1, 1'b1, 32'hFFFFFFF8, 32'd3);
    wait_done(lat, bok);
    n_checks++; if (quotient !== 32'hFFFFFFFE) $display("FAIL both_q got %h want fffffffe", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'hFFFFFFFE) $display("FAIL both_r got %h want fffffffe", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    // This start arrives mid-operation and must be ignored.
    do_start(1'b1, 1'b0, 32'd50, 32'd5);
    wait_done(lat, bok);
    n_checks++; if (lat !== 29) $display("FAIL ignore_latency got %0d want 29", lat); else n_pass++;
    n_checks++; if (quotient !== 32'd14) $display("FAIL ignore_q got %0d want 14", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'd2) $display("FAIL ignore_r got %0d want 2", remainder); else n_pass++;
    // Restart in the done cycle.
    do_start(1'b0, 1'b1, 32'd1000, 32'd33);
    wait_done(lat, bok);
    n_checks++; if (lat !== 34) $display("FAIL b2b_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (quotient !== 32'd30) $display("FAIL b2b_q got %0d want 30", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'd10) $display("FAIL b2b_r got %0d want 10", remainder); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (quotient !== 32'h0) $display("FAIL rstmid_q got %h want 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'h0) $display("FAIL rstmid_r got %h want 0", remainder); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %0b want 0", done); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_abort();
    test_contention();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
